// File: rtl/diff_core_pkg.sv
// diff_core_pkg
//   Shared definitions for the ReLU / quantise / guard write-back block.
//   PSUM_WIDTH  : default bit width of one partial-sum channel.
//   rqg_state_t : controller states of relu_quant_guard_wb.
package diff_core_pkg;

   localparam int PSUM_WIDTH = 16;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT,
      EVAL,
      EMIT,
      DONE
   } rqg_state_t;

endpackage

// File: rtl/relu_quant_lane.sv
// relu_quant_lane
//   One channel of the quantiser: arithmetic right shift, ReLU, then
//   saturation to 8-bit (0..255) or 4-bit (0..15) range.
//   psum     in  PSUM_W  signed partial sum
//   shift    in  4       arithmetic right-shift amount
//   bit_mode in  1       0 = 8-bit range, 1 = 4-bit range
//   q        out 8       quantised value (upper nibble 0 in 4-bit mode)
//   nz       out 1       quantised value is nonzero
module relu_quant_lane
   import diff_core_pkg::*;
#(
   parameter int PSUM_W = PSUM_WIDTH
) (
   input  logic signed [PSUM_W-1:0] psum,
   input  logic        [3:0]        shift,
   input  logic                     bit_mode,
   output logic        [7:0]        q,
   output logic                     nz
);

   logic signed [PSUM_W-1:0] shifted;

   // Negative values clamp to zero, large positives to the mode ceiling.
   function automatic logic [7:0] relu_sat(input logic signed [PSUM_W-1:0] v,
                                           input logic                     m);
      logic signed [PSUM_W-1:0] lim;
      lim = m ? PSUM_W'(15) : PSUM_W'(255);
      if (v[PSUM_W-1])
         return 8'd0;
      else if (v > lim)
         return lim[7:0];
      else
         return v[7:0];
   endfunction

   assign shifted = psum >>> shift;
   assign q       = relu_sat(shifted, bit_mode);
   assign nz      = |q;

endmodule

// File: rtl/relu_quant_guard_wb.sv
// relu_quant_guard_wb
//   Reads NUM_CH-channel psum words from a buffer, quantises each channel
//   (shift, ReLU, saturate) and writes feature bytes out. 8-bit mode sends a
//   nonzero-channel guard map followed by only the nonzero bytes; 4-bit mode
//   packs two channels per byte and sends every byte.
//   clk, rst_n                      clock, asynchronous active-low reset
//   ctrl_valid/ctrl_ready/ctrl_finish  job start handshake and done pulse
//   pace_i, bit_mode_i, shift_i     job configuration (latched at start)
//   rd_en, addr_o, data_i           psum buffer read port (1-cycle latency)
//   data_o, data_o_valid, fm_buf_ready         feature byte stream
//   guard_o, guard_o_valid, guard_buf_ready    guard map stream
module relu_quant_guard_wb
   import diff_core_pkg::*;
#(
   parameter int NUM_CH = 6,
   parameter int PSUM_W = PSUM_WIDTH,
   parameter int ADDR_W = 6
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     ctrl_valid,
   output logic                     ctrl_ready,
   output logic                     ctrl_finish,
   input  logic [15:0]              pace_i,
   input  logic                     bit_mode_i,
   input  logic [3:0]               shift_i,
   output logic                     rd_en,
   output logic [ADDR_W-1:0]        addr_o,
   input  logic [NUM_CH*PSUM_W-1:0] data_i,
   output logic [7:0]               data_o,
   output logic                     data_o_valid,
   input  logic                     fm_buf_ready,
   output logic [NUM_CH-1:0]        guard_o,
   output logic                     guard_o_valid,
   input  logic                     guard_buf_ready
);

   localparam int NBYTES = (NUM_CH + 1) / 2;
   localparam int BYTE_W = $clog2(NBYTES + 1);

   rqg_state_t        state;
   logic [15:0]       pace_r;
   logic [15:0]       word_cnt;
   logic              mode_r;
   logic [3:0]        shift_r;
   logic [NUM_CH-1:0] pend_p1;
   logic [BYTE_W-1:0] byte_idx;
   logic [7:0]        q_p1 [NUM_CH];

   logic [7:0]        lane_q [NUM_CH];
   logic [NUM_CH-1:0] lane_nz;
   logic [NUM_CH-1:0] sel_oh;
   logic [7:0]        q_sel;
   logic [7:0]        nib_byte [NBYTES];
   logic [7:0]        nib_sel;
   logic [15:0]       nxt_cnt;
   logic              more_words;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
      relu_quant_lane #(
         .PSUM_W (PSUM_W)
      ) u_lane (
         .psum     (data_i[i*PSUM_W +: PSUM_W]),
         .shift    (shift_r),
         .bit_mode (mode_r),
         .q        (lane_q[i]),
         .nz       (lane_nz[i])
      );
   end

   // Lowest pending channel as a one-hot: x & -x isolates the lowest set bit,
   // so the encoder scales with NUM_CH without a lookup table.
   assign sel_oh = pend_p1 & (~pend_p1 + NUM_CH'(1));

   always_comb begin
      q_sel = '0;
      for (int i = 0; i < NUM_CH; i++)
         if (sel_oh[i]) q_sel = q_sel | q_p1[i];
   end

   // 4-bit packing: even channel in the low nibble, odd in the high nibble.
   for (genvar k = 0; k < NBYTES; k++) begin : g_nib
      if (2*k + 1 < NUM_CH) begin : g_pair
         assign nib_byte[k] = {q_p1[2*k+1][3:0], q_p1[2*k][3:0]};
      end else begin : g_odd
         assign nib_byte[k] = {4'h0, q_p1[2*k][3:0]};
      end
   end

   always_comb begin
      nib_sel = '0;
      for (int k = 0; k < NBYTES; k++)
         if (byte_idx == BYTE_W'(k)) nib_sel = nib_byte[k];
   end

   assign nxt_cnt    = word_cnt + 16'd1;
   assign more_words = nxt_cnt < pace_r;

   // ---- stage p1: quantised word captured the cycle after the read ----
   always_ff @(posedge clk) begin
      if (state == WAIT) q_p1 <= lane_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         ctrl_ready    <= 1'b1;
         ctrl_finish   <= 1'b0;
         rd_en         <= 1'b0;
         addr_o        <= '0;
         data_o        <= '0;
         data_o_valid  <= 1'b0;
         guard_o       <= '0;
         guard_o_valid <= 1'b0;
         pace_r        <= '0;
         mode_r        <= 1'b0;
         shift_r       <= '0;
         word_cnt      <= '0;
         pend_p1       <= '0;
         byte_idx      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (ctrl_valid) begin
                  pace_r     <= pace_i;
                  mode_r     <= bit_mode_i;
                  shift_r    <= shift_i;
                  word_cnt   <= '0;
                  ctrl_ready <= 1'b0;
                  if (pace_i == 16'd0) begin
                     state       <= DONE;
                     ctrl_finish <= 1'b1;
                  end else begin
                     state  <= FETCH;
                     rd_en  <= 1'b1;
                     addr_o <= '0;
                  end
               end
            end

            FETCH: begin
               rd_en <= 1'b0;
               state <= WAIT;
            end

            WAIT: begin
               state    <= EVAL;
               pend_p1  <= mode_r ? '0 : lane_nz;
               byte_idx <= '0;
               if (!mode_r) begin
                  guard_o       <= lane_nz;
                  guard_o_valid <= 1'b1;
               end
            end

            EVAL: begin
               if (mode_r) begin
                  data_o       <= nib_byte[0];
                  data_o_valid <= 1'b1;
                  byte_idx     <= BYTE_W'(1);
                  state        <= EMIT;
               end else if (guard_buf_ready) begin
                  guard_o       <= '0;
                  guard_o_valid <= 1'b0;
                  if (|pend_p1) begin
                     data_o       <= q_sel;
                     data_o_valid <= 1'b1;
                     pend_p1      <= pend_p1 & ~sel_oh;
                     state        <= EMIT;
                  end else if (more_words) begin
                     // All-zero word: only its guard goes out.
                     state    <= FETCH;
                     rd_en    <= 1'b1;
                     addr_o   <= nxt_cnt[ADDR_W-1:0];
                     word_cnt <= nxt_cnt;
                  end else begin
                     state       <= DONE;
                     ctrl_finish <= 1'b1;
                  end
               end
            end

            EMIT: begin
               if (fm_buf_ready) begin
                  if (!mode_r && (|pend_p1)) begin
                     data_o  <= q_sel;
                     pend_p1 <= pend_p1 & ~sel_oh;
                  end else if (mode_r && (byte_idx < BYTE_W'(NBYTES))) begin
                     data_o   <= nib_sel;
                     byte_idx <= byte_idx + BYTE_W'(1);
                  end else begin
                     data_o       <= '0;
                     data_o_valid <= 1'b0;
                     if (more_words) begin
                        state    <= FETCH;
                        rd_en    <= 1'b1;
                        addr_o   <= nxt_cnt[ADDR_W-1:0];
                        word_cnt <= nxt_cnt;
                     end else begin
                        state       <= DONE;
                        ctrl_finish <= 1'b1;
                     end
                  end
               end
            end

            DONE: begin
               ctrl_finish <= 1'b0;
               ctrl_ready  <= 1'b1;
               state       <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
